adj_button_conditioner: RTL



---
 rtl/adj_button_conditioner.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/adj_button_conditioner.sv
// Clock-adjust button conditioner: 2-flop sync, debounce, press pulse.
// Define ADJ_AUTO_REPEAT_EN to build the hold-to-repeat FSM per channel.
module adj_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 315000,
    parameter int REPEAT_DELAY    = 15750000,
    parameter int REPEAT_PERIOD   = 3150000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] btn_in,
    output logic [2:0] adj_pulse,
    output logic [2:0] btn_level
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

`ifdef ADJ_AUTO_REPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW = $clog2(TMAX);
    localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } rep_state_t;
`endif

    logic [2:0] sync_q1;
    logic [2:0] sync_q2;

    // Bring the asynchronous pad levels into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= btn_in;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_ch
        logic [DW-1:0] cnt_q;
        logic          level_q;
        logic          pulse_q;
        logic          rise;

        // Rising edge of the debounced level, known one edge early.
        assign rise = ~level_q & sync_q2[i] & (cnt_q == DB_LAST);

        // Accept a new level only after DEBOUNCE_CYCLES of disagreement.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q   <= '0;
                level_q <= 1'b0;
            end else if (sync_q2[i] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == DB_LAST) begin
                cnt_q   <= '0;
                level_q <= ~level_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

`ifdef ADJ_AUTO_REPEAT_EN
        rep_state_t    state_q;
        rep_state_t    state_d;
        logic [TW-1:0] tmr_q;
        logic [TW-1:0] tmr_d;
        logic          pulse_d;

        // Repeat state, timer and registered pulse.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q <= ST_IDLE;
                tmr_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                tmr_q   <= tmr_d;
                pulse_q <= pulse_d;
            end
        end

        // Press pulse, then first repeat after the delay, then periodic.
        always_comb begin
            state_d = state_q;
            tmr_d   = tmr_q;
            pulse_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        pulse_d = 1'b1;
                        tmr_d   = '0;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!level_q) begin
                        tmr_d   = '0;
                        state_d = ST_IDLE;
                    end else if (tmr_q == RD_LAST) begin
                        pulse_d = 1'b1;
                        tmr_d   = '0;
                        state_d = ST_REPEAT;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!level_q) begin
                        tmr_d   = '0;
                        state_d = ST_IDLE;
                    end else if (tmr_q == RP_LAST) begin
                        pulse_d = 1'b1;
                        tmr_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
`else
        // One pulse per accepted press, aligned with the level rise.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= rise;
            end
        end
`endif

        assign btn_level[i] = level_q;
        assign adj_pulse[i] = pulse_q;
    end

endmodule
